// File: rtl/mem_dma_master_if.sv
// Command, arbitration and memory strobe bundle for mem_dma_master.
// The data bus is bidirectional and stays a plain port on the master.
interface mem_dma_master_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
);
  logic                  start;
  logic                  mode;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [ADDR_WIDTH-1:0] dst_addr;
  logic [LEN_WIDTH-1:0]  length;
  logic [DATA_WIDTH-1:0] fill_data;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  bus_req;
  logic                  bus_grant;
  logic                  mem_enable;
  logic                  mem_we_L;
  logic                  mem_re_L;
  logic [ADDR_WIDTH-1:0] mem_address;

  modport master (
    input  start, mode, src_addr, dst_addr,
    input  length, fill_data, abort, bus_grant,
    output busy, done, bus_req,
    output mem_enable, mem_we_L, mem_re_L,
    output mem_address
  );

  modport slave (
    output start, mode, src_addr, dst_addr,
    output length, fill_data, abort, bus_grant,
    input  busy, done, bus_req,
    input  mem_enable, mem_we_L, mem_re_L,
    input  mem_address
  );
endinterface

// File: rtl/mem_dma_master.sv
// Block copy / fill bus initiator for the async-read, sync-write memory.
// Arbitrates with the CPU before each byte-pair via bus_req/bus_grant.
module mem_dma_master #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset_L,
  mem_dma_master_if.master      bus,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                r_state;
  logic                  r_mode;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic [DATA_WIDTH-1:0] r_fill;
  logic [DATA_WIDTH-1:0] r_buf;

  logic                  w_rd;
  logic                  w_wr;
  logic                  w_last;
  state_t                w_resume;

  assign w_rd     = (r_state == S_READ);
  assign w_wr     = (r_state == S_WRITE);
  assign w_last   = (r_rem == LEN_WIDTH'(1));
  assign w_resume = r_mode ? S_WRITE : S_READ;

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_fill  <= '0;
      r_buf   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mode  <= bus.mode;
            r_src   <= bus.src_addr;
            r_dst   <= bus.dst_addr;
            r_rem   <= bus.length;
            r_fill  <= bus.fill_data;
            r_state <= (bus.length == '0) ? S_DONE : S_REQ;
          end
        end
        S_REQ: begin
          if (bus.abort)
            r_state <= S_IDLE;
          else if (bus.bus_grant)
            r_state <= w_resume;
        end
        S_READ: begin
          r_buf   <= mem_data;
          r_src   <= r_src + 1'b1;
          r_state <= bus.abort ? S_IDLE : S_WRITE;
        end
        S_WRITE: begin
          // The strobe was already active this cycle, so the byte lands even on abort
          r_dst <= r_dst + 1'b1;
          r_rem <= r_rem - 1'b1;
          unique case (1'b1)
            bus.abort:      r_state <= S_IDLE;
            w_last:         r_state <= S_DONE;
            !bus.bus_grant: r_state <= S_REQ;
            default:        r_state <= w_resume;
          endcase
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_DONE);
  assign bus.bus_req     = (r_state == S_REQ) || w_rd || w_wr;
  assign bus.mem_enable  = w_rd || w_wr;
  assign bus.mem_re_L    = !w_rd;
  assign bus.mem_we_L    = !w_wr;
  assign bus.mem_address = w_rd ? r_src : (w_wr ? r_dst : '0);

  assign mem_data = w_wr ? (r_mode ? r_fill : r_buf) : 'z;

endmodule

// File: tb/tb_mem_dma_master.sv
// Directed bench for mem_dma_master with a behavioural memory responder.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_mem_dma_master;

  logic       clk;
  logic       rst_n;
  wire  [7:0] mem_data;

  mem_dma_master_if #(16, 8, 16) bus ();

  mem_dma_master #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (8),
    .LEN_WIDTH  (16)
  ) dut (
    .clock    (clk),
    .reset_L  (rst_n),
    .bus      (bus.master),
    .mem_data (mem_data)
  );

  logic [7:0]  mem [0:65535];
  int          checks;
  int          failures;
  int          done_cnt;
  int          en_cnt;
  int          re_cnt;
  int          rd_n;
  logic [15:0] rd_log [0:7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_data = (bus.mem_enable && !bus.mem_re_L) ?
                    mem[bus.mem_address] : 8'hzz;

  always @(posedge clk) begin
    if (bus.mem_enable && !bus.mem_we_L)
      mem[bus.mem_address] <= mem_data;
    if (bus.done)
      done_cnt <= done_cnt + 1;
    if (bus.mem_enable)
      en_cnt <= en_cnt + 1;
    if (!bus.mem_re_L) begin
      re_cnt <= re_cnt + 1;
      if (rd_n < 8) rd_log[rd_n] <= bus.mem_address;
      rd_n <= rd_n + 1;
    end
  end

  task automatic launch(input logic md, input logic [15:0] s,
                        input logic [15:0] d, input logic [15:0] n,
                        input logic [7:0] f);
    bus.start     = 1'b1;
    bus.mode      = md;
    bus.src_addr  = s;
    bus.dst_addr  = d;
    bus.length    = n;
    bus.fill_data = f;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!bus.done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.done) cyc = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bus_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl busy=%b done=%b req=%b want 0 0 0",
               bus.busy, bus.done, bus.bus_req);
    end
    checks++;
    if (bus.mem_enable !== 1'b0 || bus.mem_we_L !== 1'b1 ||
        bus.mem_re_L !== 1'b1 || bus.mem_address !== 16'h0000) begin
      failures++;
      $display("FAIL reset_bus en=%b we_L=%b re_L=%b addr=%h want 0 1 1 0000",
               bus.mem_enable, bus.mem_we_L, bus.mem_re_L, bus.mem_address);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_copy();
    int         cyc;
    logic [7:0] exp [4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      mem[16'h1000 + i] = exp[i];
      mem[16'h2000 + i] = 8'h00;
    end
    launch(1'b0, 16'h1000, 16'h2000, 16'd4, 8'h00);
    wait_done(cyc);
    checks++;
    if (cyc !== 10) begin
      failures++;
      $display("FAIL copy_latency done_at=%0d want 10", cyc);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL copy_busy_fall busy=%b want 0", bus.busy);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16'h2000 + i] !== exp[i]) begin
        failures++;
        $display("FAIL copy_byte%0d got=%h want %h", i, mem[16'h2000 + i], exp[i]);
      end
    end
  endtask

  task automatic test_fill();
    int cyc;
    int re0;
    for (int i = 0; i < 4; i++) mem[16'h3000 + i] = 8'h00;
    re0 = re_cnt;
    launch(1'b1, 16'h0000, 16'h3000, 16'd3, 8'hA5);
    wait_done(cyc);
    checks++;
    if (cyc !== 5) begin
      failures++;
      $display("FAIL fill_latency done_at=%0d want 5", cyc);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[16'h3000 + i] !== 8'hA5) begin
        failures++;
        $display("FAIL fill_byte%0d got=%h want a5", i, mem[16'h3000 + i]);
      end
    end
    checks++;
    if (mem[16'h3003] !== 8'h00 || re_cnt !== re0) begin
      failures++;
      $display("FAIL fill_extra byte3=%h reads=%0d want 00 0",
               mem[16'h3003], re_cnt - re0);
    end
  endtask

  task automatic test_grant();
    int         cyc;
    logic [7:0] exp [3];
    exp = '{8'h5A, 8'h6B, 8'h7C};
    for (int i = 0; i < 3; i++) begin
      mem[16'h4000 + i] = exp[i];
      mem[16'h5000 + i] = 8'h00;
    end
    bus.bus_grant = 1'b0;
    launch(1'b0, 16'h4000, 16'h5000, 16'd3, 8'h00);
    repeat (5) begin
      checks++;
      if (bus.bus_req !== 1'b1 || bus.mem_enable !== 1'b0 ||
          bus.mem_we_L !== 1'b1 || bus.mem_re_L !== 1'b1) begin
        failures++;
        $display("FAIL grant_wait req=%b en=%b we_L=%b re_L=%b want 1 0 1 1",
                 bus.bus_req, bus.mem_enable, bus.mem_we_L, bus.mem_re_L);
      end
      @(negedge clk);
    end
    bus.bus_grant = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_re_L !== 1'b0 || bus.mem_address !== 16'h4000) begin
      failures++;
      $display("FAIL grant_read re_L=%b addr=%h want 0 4000",
               bus.mem_re_L, bus.mem_address);
    end
    @(negedge clk);
    bus.bus_grant = 1'b0;
    checks++;
    if (bus.mem_we_L !== 1'b0 || bus.mem_address !== 16'h5000) begin
      failures++;
      $display("FAIL grant_write we_L=%b addr=%h want 0 5000",
               bus.mem_we_L, bus.mem_address);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.bus_req !== 1'b1 || bus.mem_enable !== 1'b0 ||
          bus.mem_we_L !== 1'b1 || bus.mem_address !== 16'h0000) begin
        failures++;
        $display("FAIL grant_gap req=%b en=%b we_L=%b addr=%h want 1 0 1 0000",
                 bus.bus_req, bus.mem_enable, bus.mem_we_L, bus.mem_address);
      end
    end
    bus.bus_grant = 1'b1;
    wait_done(cyc);
    checks++;
    if (cyc < 0) begin
      failures++;
      $display("FAIL grant_timeout done_at=%0d want >0", cyc);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[16'h5000 + i] !== exp[i]) begin
        failures++;
        $display("FAIL grant_byte%0d got=%h want %h", i, mem[16'h5000 + i], exp[i]);
      end
    end
  endtask

  task automatic test_len0();
    int en0;
    en0 = en_cnt;
    launch(1'b0, 16'h1000, 16'h2000, 16'd0, 8'h00);
    checks++;
    if (bus.done !== 1'b1 || bus.bus_req !== 1'b0) begin
      failures++;
      $display("FAIL len0_done done=%b req=%b want 1 0", bus.done, bus.bus_req);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || en_cnt !== en0) begin
      failures++;
      $display("FAIL len0_idle busy=%b done=%b strobes=%0d want 0 0 0",
               bus.busy, bus.done, en_cnt - en0);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    mem[16'hFFFF] = 8'hC3;
    mem[16'h0000] = 8'h3C;
    mem[16'h6000] = 8'h00;
    mem[16'h6001] = 8'h00;
    rd_n = 0;
    launch(1'b0, 16'hFFFF, 16'h6000, 16'd2, 8'h00);
    wait_done(cyc);
    @(negedge clk);
    checks++;
    if (rd_n !== 2 || rd_log[0] !== 16'hFFFF || rd_log[1] !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_addr n=%0d a0=%h a1=%h want 2 ffff 0000",
               rd_n, rd_log[0], rd_log[1]);
    end
    checks++;
    if (mem[16'h6000] !== 8'hC3 || mem[16'h6001] !== 8'h3C) begin
      failures++;
      $display("FAIL wrap_data got=%h%h want c33c", mem[16'h6000], mem[16'h6001]);
    end
  endtask

  task automatic test_abort();
    int         cyc;
    int         d0;
    logic [7:0] got [4];
    logic [7:0] exp [4];
    exp = '{8'h81, 8'h82, 8'h00, 8'h99};
    for (int i = 0; i < 4; i++) begin
      mem[16'h7000 + i] = 8'h81 + 8'(i);
      mem[16'h8000 + i] = 8'h00;
    end
    d0 = done_cnt;
    launch(1'b0, 16'h7000, 16'h8000, 16'd4, 8'h00);
    repeat (4) @(negedge clk);
    checks++;
    if (bus.mem_we_L !== 1'b0 || bus.mem_address !== 16'h8001) begin
      failures++;
      $display("FAIL abort_at we_L=%b addr=%h want 0 8001",
               bus.mem_we_L, bus.mem_address);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_enable !== 1'b0 || bus.bus_req !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle busy=%b en=%b req=%b want 0 0 0",
               bus.busy, bus.mem_enable, bus.bus_req);
    end
    launch(1'b1, 16'h0000, 16'h8003, 16'd1, 8'h99);
    wait_done(cyc);
    checks++;
    if (cyc !== 3) begin
      failures++;
      $display("FAIL abort_restart done_at=%0d want 3", cyc);
    end
    @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1) begin
      failures++;
      $display("FAIL abort_no_done pulses=%0d want 1", done_cnt - d0);
    end
    for (int i = 0; i < 4; i++) begin
      got[i] = mem[16'h8000 + i];
      checks++;
      if (got[i] !== exp[i]) begin
        failures++;
        $display("FAIL abort_byte%0d got=%h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    mem[16'h9000] = 8'hD1;
    mem[16'h9001] = 8'hD2;
    mem[16'hA000] = 8'h00;
    launch(1'b0, 16'h9000, 16'hA000, 16'd2, 8'h00);
    @(negedge clk);
    checks++;
    if (bus.mem_re_L !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_read re_L=%b want 0", bus.mem_re_L);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bus_req !== 1'b0 ||
        bus.mem_enable !== 1'b0 || bus.mem_we_L !== 1'b1 ||
        bus.mem_re_L !== 1'b1 || bus.mem_address !== 16'h0000) begin
      failures++;
      $display("FAIL rstmid_outs busy=%b done=%b req=%b en=%b we_L=%b re_L=%b addr=%h",
               bus.busy, bus.done, bus.bus_req, bus.mem_enable,
               bus.mem_we_L, bus.mem_re_L, bus.mem_address);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (mem[16'hA000] !== 8'h00 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_dst got=%h busy=%b want 00 0", mem[16'hA000], bus.busy);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    done_cnt      = 0;
    en_cnt        = 0;
    re_cnt        = 0;
    rd_n          = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.mode      = 1'b0;
    bus.src_addr  = '0;
    bus.dst_addr  = '0;
    bus.length    = '0;
    bus.fill_data = '0;
    bus.abort     = 1'b0;
    bus.bus_grant = 1'b1;
    @(negedge clk);
    test_reset();
    test_copy();
    test_fill();
    test_grant();
    test_len0();
    test_wrap();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
